// File: rtl/constants_pkg.sv
// Shared widths and types for the GPU memory-side blocks.
package constants_pkg;

    localparam int ADDR_WIDTH              = 32;
    localparam int DATA_WIDTH              = 32;
    localparam int MAX_OUTSTANDING_DEFAULT = 4;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [DATA_WIDTH-1:0] data_t;

endpackage

// File: rtl/gpu_id_fifo.sv
// Small synchronous FIFO holding the consumer index of every request that has
// been granted but not yet answered. Its count doubles as the outstanding
// transaction counter.
module gpu_id_fifo #(
    parameter  int WIDTH = 2,
    parameter  int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; an entry is only
        // read after it has been written, and leaving it out keeps it a plain
        // register file / RAM.
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/gpu_mem_arbiter.sv
// Round-robin read-request arbiter in front of the GPU memory channel, with
// in-order routing of memory responses back to the issuing consumer.
module gpu_mem_arbiter #(
    parameter int NUM_CONSUMERS   = 4,
    parameter int MAX_OUTSTANDING = constants_pkg::MAX_OUTSTANDING_DEFAULT,
    parameter int ADDR_WIDTH      = constants_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH      = constants_pkg::DATA_WIDTH
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_CONSUMERS-1:0]            c_req_vld,
    output logic [NUM_CONSUMERS-1:0]            c_req_rdy,
    input  logic [NUM_CONSUMERS*ADDR_WIDTH-1:0] c_req_addr,
    output logic [NUM_CONSUMERS-1:0]            c_rsp_vld,
    input  logic [NUM_CONSUMERS-1:0]            c_rsp_rdy,
    output logic [DATA_WIDTH-1:0]               c_rsp_data,
    output logic                                m_req_vld,
    input  logic                                m_req_rdy,
    output logic [ADDR_WIDTH-1:0]               m_req_addr,
    input  logic                                m_rsp_vld,
    output logic                                m_rsp_rdy,
    input  logic [DATA_WIDTH-1:0]               m_rsp_data,
    output logic                                proto_err
);

    import constants_pkg::*;

    localparam int ID_W  = $clog2(NUM_CONSUMERS);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  winner;
    logic [ID_W-1:0]  head;
    logic             any_req;
    logic             out_free;
    logic             can_grant;
    logic             grant;
    logic             rsp_pop;
    logic             id_full;
    logic             id_empty;
    logic [CNT_W-1:0] id_count;
    int               idx;

    // The output register can take a new request when idle or draining now.
    // Fullness uses the current count only, so a same-cycle pop never makes
    // room for a same-cycle grant.
    assign out_free  = !m_req_vld || m_req_rdy;
    assign can_grant = out_free && !id_full;
    assign grant     = !rst && can_grant && any_req;

    // Round-robin pick: scan from the farthest offset down so the nearest
    // requester at or after rr_ptr is the last (winning) assignment.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned and no latch is inferred.
        any_req = 1'b0;
        winner  = '0;
        idx     = 0;
        for (int k = NUM_CONSUMERS - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_CONSUMERS) idx = idx - NUM_CONSUMERS;
            if (c_req_vld[idx]) begin
                winner  = ID_W'(idx);
                any_req = 1'b1;
            end
        end
    end

    // One-hot accept to the winning consumer.
    always_comb begin
        c_req_rdy = '0;
        if (grant) c_req_rdy[winner] = 1'b1;
    end

    // Response routing to the consumer at the head of the ID FIFO.
    always_comb begin
        c_rsp_vld = '0;
        m_rsp_rdy = 1'b0;
        if (!rst && !id_empty) begin
            c_rsp_vld[head] = m_rsp_vld;
            m_rsp_rdy       = c_rsp_rdy[head];
        end
    end

    assign c_rsp_data = m_rsp_data;
    assign rsp_pop    = m_rsp_vld && m_rsp_rdy;

    // Memory request register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_req_vld  <= 1'b0;
            m_req_addr <= '0;
            rr_ptr     <= '0;
        end else if (grant) begin
            m_req_vld  <= 1'b1;
            m_req_addr <= c_req_addr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
            rr_ptr     <= (winner == ID_W'(NUM_CONSUMERS - 1)) ? '0 : winner + ID_W'(1);
        end else if (m_req_rdy) begin
            m_req_vld  <= 1'b0;
        end
    end

    // Sticky flag for a memory response with nothing outstanding.
    always_ff @(posedge clk) begin
        if (rst) begin
            proto_err <= 1'b0;
        end else if (m_rsp_vld && id_count == '0) begin
            proto_err <= 1'b1;
        end
    end

    gpu_id_fifo #(
        .WIDTH (ID_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (grant),
        .din   (winner),
        .pop   (rsp_pop),
        .dout  (head),
        .full  (id_full),
        .empty (id_empty),
        .count (id_count)
    );

endmodule

// File: tb/tb_gpu_mem_arbiter.sv
// Bench for gpu_mem_arbiter: directed scenarios plus a randomized run checked
// against a queue-based reference model.
module tb_gpu_mem_arbiter;

    localparam int N    = 4;
    localparam int MAXO = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    c_req_vld;
    logic [N-1:0]    c_req_rdy;
    logic [N*AW-1:0] c_req_addr;
    logic [N-1:0]    c_rsp_vld;
    logic [N-1:0]    c_rsp_rdy;
    logic [DW-1:0]   c_rsp_data;
    logic            m_req_vld;
    logic            m_req_rdy;
    logic [AW-1:0]   m_req_addr;
    logic            m_rsp_vld;
    logic            m_rsp_rdy;
    logic [DW-1:0]   m_rsp_data;
    logic            proto_err;

    logic [AW-1:0]   addr_arr [N];

    int errors = 0;
    int checks = 0;

    // Reference model state.
    int            exp_q[$];
    bit            exp_mvld;
    logic [AW-1:0] exp_maddr;
    int            exp_rr;
    bit            exp_perr;

    // Automatic memory responder state.
    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } rsp_t;
    rsp_t mem_q[$];
    bit   auto_rsp = 1'b0;
    int   cyc = 0;
    bit   req_fire;
    bit   rsp_fire;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_addr
        assign c_req_addr[g*AW +: AW] = addr_arr[g];
    end

    gpu_mem_arbiter #(
        .NUM_CONSUMERS   (N),
        .MAX_OUTSTANDING (MAXO),
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .c_req_vld  (c_req_vld),
        .c_req_rdy  (c_req_rdy),
        .c_req_addr (c_req_addr),
        .c_rsp_vld  (c_rsp_vld),
        .c_rsp_rdy  (c_rsp_rdy),
        .c_rsp_data (c_rsp_data),
        .m_req_vld  (m_req_vld),
        .m_req_rdy  (m_req_rdy),
        .m_req_addr (m_req_addr),
        .m_rsp_vld  (m_rsp_vld),
        .m_rsp_rdy  (m_rsp_rdy),
        .m_rsp_data (m_rsp_data),
        .proto_err  (proto_err)
    );

    // ---------------- reference model ----------------
    function automatic int rr_pick(logic [N-1:0] v, int start);
        for (int k = 0; k < N; k++) begin
            if (v[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_req_rdy();
        bit can;
        int w;
        if (rst) return '0;
        can = (!exp_mvld || m_req_rdy) && (exp_q.size() < MAXO);
        w   = rr_pick(c_req_vld, exp_rr);
        if (can && w >= 0) return N'(1) << w;
        return '0;
    endfunction

    function automatic logic [N-1:0] exp_rsp_vld();
        if (rst || exp_q.size() == 0 || !m_rsp_vld) return '0;
        return N'(1) << exp_q[0];
    endfunction

    function automatic logic exp_m_rsp_rdy();
        if (rst || exp_q.size() == 0) return 1'b0;
        return c_rsp_rdy[exp_q[0]];
    endfunction

    // Advances the model by one clock using the inputs present before the edge.
    task automatic model_update();
        logic [N-1:0] g;
        bit           p;
        int           w;
        if (rst) begin
            exp_q.delete();
            exp_mvld  = 1'b0;
            exp_maddr = '0;
            exp_rr    = 0;
            exp_perr  = 1'b0;
        end else begin
            g = exp_req_rdy();
            p = exp_m_rsp_rdy() && m_rsp_vld;
            if (exp_q.size() == 0 && m_rsp_vld) exp_perr = 1'b1;
            if (g != '0) begin
                w         = rr_pick(c_req_vld, exp_rr);
                exp_mvld  = 1'b1;
                exp_maddr = addr_arr[w];
                exp_q.push_back(w);
                exp_rr    = (w + 1) % N;
            end else if (m_req_rdy) begin
                exp_mvld = 1'b0;
            end
            if (p) void'(exp_q.pop_front());
        end
    endtask

    // Called at a negedge: samples handshakes, steps the model, crosses the
    // rising edge and then updates the automatic memory responder.
    task automatic tick();
        rsp_t r;
        req_fire = m_req_vld && m_req_rdy;
        rsp_fire = m_rsp_vld && m_rsp_rdy;
        model_update();
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            mem_q.delete();
            if (auto_rsp) m_rsp_vld = 1'b0;
        end else if (auto_rsp) begin
            if (rsp_fire && mem_q.size() > 0) void'(mem_q.pop_front());
            if (req_fire) begin
                r.due  = cyc + 3;
                r.data = $urandom;
                mem_q.push_back(r);
            end
        end
        if (auto_rsp) begin
            if (mem_q.size() > 0 && cyc >= mem_q[0].due) begin
                m_rsp_vld  = 1'b1;
                m_rsp_data = mem_q[0].data;
            end else begin
                m_rsp_vld  = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        auto_rsp  = 1'b0;
        c_req_vld = '0;
        m_rsp_vld = 1'b0;
        c_rsp_rdy = '1;
        m_req_rdy = 1'b1;
        @(negedge clk); tick();
        @(negedge clk); tick();
        rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst       = 1'b1;
        c_req_vld = '1;
        c_rsp_rdy = '1;
        m_req_rdy = 1'b1;
        m_rsp_vld = 1'b0;
        m_rsp_data = '0;
        for (int i = 0; i < N; i++) addr_arr[i] = AW'(32'h100 + i);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (c_req_rdy !== '0) begin errors++; $display("FAIL reset_c_req_rdy got=%b want=0000", c_req_rdy); end
            checks++; if (m_req_vld !== 1'b0) begin errors++; $display("FAIL reset_m_req_vld got=%b want=0", m_req_vld); end
            checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_proto_err got=%b want=0", proto_err); end
            tick();
        end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (c_req_rdy !== 4'b0001) begin errors++; $display("FAIL reset_first_grant got=%b want=0001", c_req_rdy); end
        tick();
        @(negedge clk);
        checks++; if (m_req_vld !== 1'b1 || m_req_addr !== 32'h100) begin
            errors++; $display("FAIL reset_first_req vld=%b addr=%h want vld=1 addr=00000100", m_req_vld, m_req_addr);
        end
        tick();
    endtask

    task automatic test_fairness();
        int            ngrant = 0;
        bit            pending = 1'b0;
        logic [AW-1:0] last_addr;
        logic [N-1:0]  want;
        int            budget = 0;
        do_reset();
        addr_arr[0] = 32'h10; addr_arr[1] = 32'h21; addr_arr[2] = 32'h32; addr_arr[3] = 32'h43;
        auto_rsp  = 1'b1;
        c_req_vld = '1;
        while ((ngrant < 6 || pending) && budget < 60) begin
            @(negedge clk);
            if (pending) begin
                checks++; if (m_req_vld !== 1'b1 || m_req_addr !== last_addr) begin
                    errors++; $display("FAIL fair_addr vld=%b addr=%h want vld=1 addr=%h", m_req_vld, m_req_addr, last_addr);
                end
                pending = 1'b0;
            end
            if (c_req_rdy !== '0 && ngrant < 6) begin
                want = N'(1) << (ngrant % N);
                checks++; if (c_req_rdy !== want) begin
                    errors++; $display("FAIL fair_order grant#%0d got=%b want=%b", ngrant, c_req_rdy, want);
                end
                last_addr = addr_arr[ngrant % N];
                pending   = 1'b1;
                ngrant++;
            end
            tick();
            budget++;
        end
        checks++; if (ngrant < 6) begin errors++; $display("FAIL fair_timeout grants=%0d want=6", ngrant); end
    endtask

    task automatic test_outstanding_limit();
        int grants = 0;
        do_reset();
        for (int i = 0; i < N; i++) addr_arr[i] = AW'(32'h200 + i);
        c_req_vld = '1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            grants += $countones(c_req_rdy);
            tick();
        end
        checks++; if (grants != MAXO) begin errors++; $display("FAIL limit_grants got=%0d want=%0d", grants, MAXO); end
        @(negedge clk);
        checks++; if (c_req_rdy !== '0) begin errors++; $display("FAIL limit_stall got=%b want=0000", c_req_rdy); end
        tick();
        m_rsp_vld  = 1'b1;
        m_rsp_data = 32'h5555_0000;
        @(negedge clk);
        checks++; if (m_rsp_rdy !== 1'b1 || c_rsp_vld !== 4'b0001) begin
            errors++; $display("FAIL limit_pop m_rsp_rdy=%b c_rsp_vld=%b want 1 0001", m_rsp_rdy, c_rsp_vld);
        end
        checks++; if (c_req_rdy !== '0) begin errors++; $display("FAIL limit_same_cycle got=%b want=0000", c_req_rdy); end
        tick();
        m_rsp_vld = 1'b0;
        @(negedge clk);
        checks++; if (c_req_rdy !== 4'b0001) begin errors++; $display("FAIL limit_regrant got=%b want=0001", c_req_rdy); end
        tick();
        @(negedge clk);
        checks++; if (c_req_rdy !== '0) begin errors++; $display("FAIL limit_single got=%b want=0000", c_req_rdy); end
        tick();
    endtask

    task automatic test_routing();
        do_reset();
        addr_arr[2] = 32'h80; addr_arr[1] = 32'h81;
        c_req_vld = 4'b0100;
        @(negedge clk);
        checks++; if (c_req_rdy !== 4'b0100) begin errors++; $display("FAIL route_grant2 got=%b want=0100", c_req_rdy); end
        tick();
        c_req_vld = 4'b0010;
        @(negedge clk);
        checks++; if (c_req_rdy !== 4'b0010 || m_req_addr !== 32'h80) begin
            errors++; $display("FAIL route_grant1 rdy=%b addr=%h want 0010 00000080", c_req_rdy, m_req_addr);
        end
        tick();
        c_req_vld = '0;
        @(negedge clk);
        checks++; if (m_req_vld !== 1'b1 || m_req_addr !== 32'h81) begin
            errors++; $display("FAIL route_req2 vld=%b addr=%h want 1 00000081", m_req_vld, m_req_addr);
        end
        tick();
        m_rsp_vld = 1'b1; m_rsp_data = 32'hAA;
        @(negedge clk);
        checks++; if (c_rsp_vld !== 4'b0100 || c_rsp_data !== 32'hAA) begin
            errors++; $display("FAIL route_rsp1 vld=%b data=%h want 0100 000000aa", c_rsp_vld, c_rsp_data);
        end
        tick();
        m_rsp_data = 32'hBB;
        @(negedge clk);
        checks++; if (c_rsp_vld !== 4'b0010 || c_rsp_data !== 32'hBB) begin
            errors++; $display("FAIL route_rsp2 vld=%b data=%h want 0010 000000bb", c_rsp_vld, c_rsp_data);
        end
        tick();
        m_rsp_vld = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < N; i++) addr_arr[i] = AW'(32'h300 + 16 * i);
        c_req_vld = '1;
        m_req_rdy = 1'b0;
        @(negedge clk);
        checks++; if (c_req_rdy !== 4'b0001) begin errors++; $display("FAIL bp_first got=%b want=0001", c_req_rdy); end
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (m_req_vld !== 1'b1 || m_req_addr !== 32'h300 || c_req_rdy !== '0) begin
                errors++; $display("FAIL bp_hold cyc%0d vld=%b addr=%h rdy=%b want 1 00000300 0000", i, m_req_vld, m_req_addr, c_req_rdy);
            end
            tick();
        end
        m_req_rdy = 1'b1;
        @(negedge clk);
        checks++; if (c_req_rdy !== 4'b0010) begin errors++; $display("FAIL bp_release got=%b want=0010", c_req_rdy); end
        tick();

        do_reset();
        addr_arr[3] = 32'h333;
        c_req_vld = 4'b1000;
        @(negedge clk); tick();
        c_req_vld = '0;
        @(negedge clk); tick();
        m_rsp_vld = 1'b1; m_rsp_data = 32'h1234;
        c_rsp_rdy = 4'b0111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (m_rsp_rdy !== 1'b0 || c_rsp_vld !== 4'b1000) begin
                errors++; $display("FAIL bp_rsp_stall m_rsp_rdy=%b c_rsp_vld=%b want 0 1000", m_rsp_rdy, c_rsp_vld);
            end
            tick();
        end
        c_rsp_rdy = '1;
        @(negedge clk);
        checks++; if (m_rsp_rdy !== 1'b1) begin errors++; $display("FAIL bp_rsp_go got=%b want=1", m_rsp_rdy); end
        tick();
        m_rsp_vld = 1'b0;
        @(negedge clk);
        checks++; if (c_rsp_vld !== '0 || proto_err !== 1'b0) begin
            errors++; $display("FAIL bp_drained c_rsp_vld=%b proto_err=%b want 0000 0", c_rsp_vld, proto_err);
        end
        tick();
    endtask

    task automatic test_proto_err();
        do_reset();
        m_rsp_vld = 1'b1; m_rsp_data = 32'hDEAD;
        @(negedge clk);
        checks++; if (m_rsp_rdy !== 1'b0 || c_rsp_vld !== '0 || proto_err !== 1'b0) begin
            errors++; $display("FAIL perr_empty m_rsp_rdy=%b c_rsp_vld=%b proto_err=%b want 0 0000 0", m_rsp_rdy, c_rsp_vld, proto_err);
        end
        tick();
        m_rsp_vld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL perr_sticky cyc%0d got=%b want=1", i, proto_err); end
            tick();
        end
        rst = 1'b1;
        @(negedge clk); tick();
        @(negedge clk);
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL perr_clear got=%b want=0", proto_err); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        auto_rsp = 1'b1;
        for (int i = 0; i < 400; i++) begin
            c_req_vld = N'($urandom);
            for (int j = 0; j < N; j++) addr_arr[j] = AW'($urandom);
            m_req_rdy = ($urandom_range(3) != 0);
            c_rsp_rdy = N'($urandom) | N'($urandom);
            @(negedge clk);
            checks++; if (c_req_rdy !== exp_req_rdy()) begin
                errors++; $display("FAIL rnd_c_req_rdy cyc%0d got=%b want=%b", i, c_req_rdy, exp_req_rdy());
            end
            checks++; if (m_req_vld !== exp_mvld || m_req_addr !== exp_maddr) begin
                errors++; $display("FAIL rnd_m_req cyc%0d vld=%b addr=%h want %b %h", i, m_req_vld, m_req_addr, exp_mvld, exp_maddr);
            end
            checks++; if (c_rsp_vld !== exp_rsp_vld() || m_rsp_rdy !== exp_m_rsp_rdy()) begin
                errors++; $display("FAIL rnd_rsp cyc%0d c_rsp_vld=%b m_rsp_rdy=%b want %b %b", i, c_rsp_vld, m_rsp_rdy, exp_rsp_vld(), exp_m_rsp_rdy());
            end
            checks++; if (c_rsp_data !== m_rsp_data || proto_err !== exp_perr) begin
                errors++; $display("FAIL rnd_misc cyc%0d data=%h proto_err=%b want %h %b", i, c_rsp_data, proto_err, m_rsp_data, exp_perr);
            end
            tick();
        end
        auto_rsp = 1'b0;
        m_rsp_vld = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_outstanding_limit();
        test_routing();
        test_backpressure();
        test_proto_err();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/gpu_mem_arbiter.md
Name: gpu_mem_arbiter

Overview:
Read-request arbiter and response router placed directly upstream of the GPU memory channel. It collects address requests from NUM_CONSUMERS core load/fetch units and selects one per cycle with round-robin arbitration. The selected request is registered onto the single memory request channel. Memory responses return in order, and the block routes each one back to the consumer that issued it, using an in-order ID FIFO that also bounds outstanding transactions.

Parameters:
NUM_CONSUMERS, 4, number of requesting units (>=2)
MAX_OUTSTANDING, 4, ID FIFO depth; max requests granted but not yet answered (power of 2)
ADDR_WIDTH, constants_pkg::ADDR_WIDTH, request address width
DATA_WIDTH, constants_pkg::DATA_WIDTH, response data width

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
c_req_vld  input  NUM_CONSUMERS  per-consumer request valid
c_req_rdy  output  NUM_CONSUMERS  per-consumer request accepted this cycle
c_req_addr  input  NUM_CONSUMERS*ADDR_WIDTH  packed per-consumer addresses; consumer i at [i*ADDR_WIDTH +: ADDR_WIDTH]
c_rsp_vld  output  NUM_CONSUMERS  per-consumer response valid
c_rsp_rdy  input  NUM_CONSUMERS  per-consumer response ready
c_rsp_data  output  DATA_WIDTH  response data, broadcast; qualified by c_rsp_vld
m_req_vld  output  1  memory request valid
m_req_rdy  input  1  memory request ready
m_req_addr  output  ADDR_WIDTH  memory request address
m_rsp_vld  input  1  memory response valid
m_rsp_rdy  output  1  memory response ready
proto_err  output  1  sticky; set when a memory response arrives with no outstanding request

Behaviour:
- Handshake rule: a transfer occurs on any channel when vld && rdy at the clock edge.
- Valid stability: once m_req_vld is asserted, the block holds it and m_req_addr stable until accepted.
- Reset state, when rst is high at an edge:
  - m_req_vld=0, m_req_addr=0.
  - ID FIFO empty, outstanding count 0.
  - RR pointer 0 (consumer 0 highest priority).
  - proto_err=0.
  - All combinational outputs (c_req_rdy, c_rsp_vld, m_rsp_rdy) are forced 0 while rst=1.
- Reset mid-operation discards all in-flight state. Responses for discarded requests are not routed.
- Request path:
  - The output register is free when m_req_vld=0 or m_req_vld && m_req_rdy.
  - can_grant = free && (count < MAX_OUTSTANDING).
  - Full is evaluated on the current count; a same-cycle pop does not free a slot for a same-cycle grant.
  - Arbiter: the first i with c_req_vld[i], searching from the RR pointer upward and wrapping modulo NUM_CONSUMERS.
  - c_req_rdy is one-hot: only the winner's bit is set, and only when can_grant. c_req_rdy does not depend on c_req_rdy inputs from other channels.
  - On a grant:
    - m_req_addr <= winner address, m_req_vld <= 1 at the next edge.
    - The winner index is pushed into the ID FIFO.
    - The RR pointer <= (winner+1) mod NUM_CONSUMERS.
  - With no grant, the RR pointer holds.
  - With no grant and m_req_rdy accepted, m_req_vld <= 0.
  - Latency: consumer accept to m_req_vld is 1 cycle.
  - Back-to-back grants are allowed every cycle while m_req_rdy=1.
- Response path (combinational, zero latency):
  - head = ID FIFO head.
  - With FIFO not empty: c_rsp_vld[head] = m_rsp_vld, and m_rsp_rdy = c_rsp_rdy[head]. All other c_rsp_vld bits are 0.
  - c_rsp_data = m_rsp_data.
  - On m_rsp_vld && m_rsp_rdy, the head is popped.
- Count arithmetic: count += push − pop, clog2(MAX_OUTSTANDING+1) bits. Simultaneous push and pop leaves count unchanged. Pointers wrap modulo MAX_OUTSTANDING.
- Empty-FIFO response: m_rsp_rdy=0, no c_rsp_vld asserted; m_rsp_vld=1 in that state sets proto_err=1 until reset.

Decomposition:
- constants_pkg gains MAX_OUTSTANDING_DEFAULT and the typedefs addr_t (ADDR_WIDTH) and data_t (DATA_WIDTH).
- Sub-module gpu_id_fifo: synchronous FIFO, parameterised width and depth, with push/pop/full/empty/count. It holds consumer indices of width clog2(NUM_CONSUMERS).
- The round-robin arbiter stays inline.

Test Plan:
- Reset: rst=1 for 2 cycles with all c_req_vld=1 -> c_req_rdy=0, m_req_vld=0, proto_err=0. After release: first grant goes to consumer 0, and m_req_vld=1 one cycle later.
- Fairness: all 4 consumers request continuously, m_req_rdy=1, memory answers each request after 3 cycles -> grants follow the order 0,1,2,3,0,1. m_req_addr carries the matching addresses 0x10,0x21,0x32,0x43.
- Outstanding limit: m_rsp_vld held 0, requests continuous -> exactly 4 grants, then c_req_rdy=0. One response pops one entry -> exactly one new grant on the following cycle.
- Routing: consumer 2 requests 0x80, then consumer 1 requests 0x81; memory returns 0xAA then 0xBB -> c_rsp_vld[2] with 0xAA, then c_rsp_vld[1] with 0xBB.
- Backpressure: m_req_rdy=0 for 5 cycles -> m_req_vld and m_req_addr held stable, no further grants. Consumer 3 with c_rsp_rdy[3]=0 -> m_rsp_rdy=0 until it rises.
- Protocol error: m_rsp_vld=1 with nothing outstanding -> m_rsp_rdy=0, proto_err=1, which stays set until rst.
